// File: rtl/imem_loader_if.sv
// Stream and instruction-memory write bus between a byte-stream host and imem_loader.
// The slave modport is the loader side; the master modport is the host/memory side.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        clr;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        load_ok;
    logic        err;

    modport slave (
        input  in_data, in_valid, clr,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, load_ok, err
    );

    modport master (
        output in_data, in_valid, clr,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, load_ok, err
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream programmer for the instruction memory: assembles big-endian words,
// writes them, stalls the pipeline while loading and verifies an XOR payload checksum.
module imem_loader #(
    parameter int          DEPTH_WORDS = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_HI = 3'd1,
        S_CNT_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_word_done;
    logic        w_start;
    logic [15:0] w_count;

    logic        r_in_ready;
    logic [7:0]  r_cnt_hi;
    logic [15:0] r_count;
    logic [15:0] r_idx;
    logic [1:0]  r_bcnt;
    logic [23:0] r_asm;
    logic [7:0]  r_acc;
    logic        r_wr_en;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_hold;
    logic        r_done;
    logic        r_load_ok;
    logic        r_err;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_start  = (r_state == S_IDLE) && w_accept && (bus.in_data == SYNC_BYTE);
    assign w_count  = {r_cnt_hi, bus.in_data};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and word-complete strobe.
    always_comb begin
        w_next      = r_state;
        w_word_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next = S_CNT_HI;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CNT_HI: begin
                if (w_accept) begin
                    w_next = S_CNT_LO;
                end else begin
                    w_next = S_CNT_HI;
                end
            end
            S_CNT_LO: begin
                if (!w_accept) begin
                    w_next = S_CNT_LO;
                end else if ({1'b0, w_count} > DEPTH_L) begin
                    w_next = S_ERR;
                end else if (w_count == 16'd0) begin
                    w_next = S_CSUM;
                end else begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && (r_bcnt == 2'd3)) begin
                    w_word_done = 1'b1;
                    if (r_idx == (r_count - 16'd1)) begin
                        w_next = S_CSUM;
                    end else begin
                        w_next = S_DATA;
                    end
                end else begin
                    w_next = S_DATA;
                end
            end
            S_CSUM: begin
                if (!w_accept) begin
                    w_next = S_CSUM;
                end else if (bus.in_data == r_acc) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_ERR;
                end
            end
            S_ERR: begin
                if (bus.clr) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_ERR;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; level outputs follow the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_in_ready <= 1'b0;
            r_cnt_hi   <= 8'd0;
            r_count    <= 16'd0;
            r_idx      <= 16'd0;
            r_bcnt     <= 2'd0;
            r_asm      <= 24'd0;
            r_acc      <= 8'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= 32'd0;
            r_wr_data  <= 32'd0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_load_ok  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_in_ready <= (w_next != S_ERR);
            r_hold     <= (w_next == S_CNT_HI) || (w_next == S_CNT_LO) ||
                          (w_next == S_DATA)   || (w_next == S_CSUM);
            r_err      <= (w_next == S_ERR);
            r_wr_en    <= w_word_done;
            r_done     <= (r_state == S_CSUM) && w_accept;
            if (w_start) begin
                r_acc     <= 8'd0;
                r_idx     <= 16'd0;
                r_bcnt    <= 2'd0;
                r_load_ok <= 1'b0;
            end
            if (w_accept) begin
                case (r_state)
                    S_CNT_HI: r_cnt_hi <= bus.in_data;
                    S_CNT_LO: r_count  <= w_count;
                    S_DATA: begin
                        r_asm  <= {r_asm[15:0], bus.in_data};
                        r_acc  <= r_acc ^ bus.in_data;
                        r_bcnt <= r_bcnt + 2'd1;
                        if (w_word_done) begin
                            r_wr_data <= {r_asm, bus.in_data};
                            r_wr_addr <= BASE_ADDR + {14'd0, r_idx, 2'b00};
                            r_idx     <= r_idx + 16'd1;
                        end
                    end
                    S_CSUM: begin
                        if (bus.in_data == r_acc) begin
                            r_load_ok <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_data  = r_wr_data;
    assign bus.cpu_hold = r_hold;
    assign bus.done     = r_done;
    assign bus.load_ok  = r_load_ok;
    assign bus.err      = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, zero and over-count, idle noise,
// in_valid stalls and mid-frame reset, each checked against hand-computed values.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if bus();

    imem_loader #(
        .DEPTH_WORDS(16),
        .BASE_ADDR(32'h0000_0000),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/done/hold capture, sampled on the falling edge.
    logic [31:0] mon_addr [0:63];
    logic [31:0] mon_data [0:63];
    int          mon_cyc  [0:63];
    int wr_count = 0;
    int done_count = 0;
    int hold_count = 0;
    always @(negedge clk) begin
        if (bus.wr_en) begin
            if (wr_count < 64) begin
                mon_addr[wr_count] <= bus.wr_addr;
                mon_data[wr_count] <= bus.wr_data;
                mon_cyc[wr_count]  <= cyc;
            end
            wr_count <= wr_count + 1;
        end
        if (bus.done) done_count <= done_count + 1;
        if (bus.cpu_hold) hold_count <= hold_count + 1;
    end

    logic [7:0] good_fr [0:11] = '{8'hA5, 8'h00, 8'h02, 8'h8C, 8'h22, 8'h00,
                                   8'h0A, 8'hAC, 8'h23, 8'h00, 8'h05, 8'h2E};
    logic [7:0] frame [0:15];
    int frame_len = 0;

    task automatic send_frame(input int gap);
        for (int i = 0; i < frame_len; i++) begin
            bus.in_data  = frame[i];
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (i != frame_len - 1 && gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic load_good(input logic [7:0] last);
        for (int i = 0; i < 12; i++) frame[i] = good_fr[i];
        frame[11] = last;
        frame_len = 12;
    endtask

    task automatic check_two_writes(input string tag, input int base, input int spacing);
        n_tests++;
        if (wr_count - base !== 2) begin
            n_fail++; $display("FAIL %s_nwr got %0d want 2", tag, wr_count - base);
        end
        n_tests++;
        if (mon_addr[base] !== 32'h0 || mon_data[base] !== 32'h8C22000A) begin
            n_fail++; $display("FAIL %s_w0 got %h@%h want 8c22000a@00000000", tag, mon_data[base], mon_addr[base]);
        end
        n_tests++;
        if (mon_addr[base+1] !== 32'h4 || mon_data[base+1] !== 32'hAC230005) begin
            n_fail++; $display("FAIL %s_w1 got %h@%h want ac230005@00000004", tag, mon_data[base+1], mon_addr[base+1]);
        end
        n_tests++;
        if (mon_cyc[base+1] - mon_cyc[base] !== spacing) begin
            n_fail++; $display("FAIL %s_spacing got %0d want %0d", tag, mon_cyc[base+1] - mon_cyc[base], spacing);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.in_ready, bus.wr_en, bus.cpu_hold, bus.done, bus.load_ok, bus.err} !== 6'b0 ||
            bus.wr_addr !== 32'h0 || bus.wr_data !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs got rdy=%b we=%b hold=%b done=%b ok=%b err=%b a=%h d=%h want all 0",
                bus.in_ready, bus.wr_en, bus.cpu_hold, bus.done, bus.load_ok, bus.err, bus.wr_addr, bus.wr_data);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_good_frame;
        int base, hbase;
        base = wr_count; hbase = hold_count;
        load_good(8'h2E);
        send_frame(0);
        check_two_writes("good", base, 4);
        n_tests++;
        if (bus.done !== 1'b1 || bus.load_ok !== 1'b1 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL good_status got done=%b ok=%b err=%b want 1 1 0", bus.done, bus.load_ok, bus.err);
        end
        n_tests++;
        if (hold_count - hbase !== 11 || bus.cpu_hold !== 1'b0) begin
            n_fail++; $display("FAIL good_hold got cycles=%0d now=%b want 11 0", hold_count - hbase, bus.cpu_hold);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.done !== 1'b0 || bus.load_ok !== 1'b1) begin
            n_fail++; $display("FAIL good_done_pulse got done=%b ok=%b want 0 1", bus.done, bus.load_ok);
        end
    endtask

    task automatic test_bad_checksum;
        int base;
        base = wr_count;
        load_good(8'h2F);
        send_frame(0);
        check_two_writes("bad", base, 4);
        n_tests++;
        if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.load_ok !== 1'b0 ||
            bus.in_ready !== 1'b0 || bus.cpu_hold !== 1'b0) begin
            n_fail++; $display("FAIL bad_status got done=%b err=%b ok=%b rdy=%b hold=%b want 1 1 0 0 0",
                bus.done, bus.err, bus.load_ok, bus.in_ready, bus.cpu_hold);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.err !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL bad_sticky got err=%b done=%b want 1 0", bus.err, bus.done);
        end
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        n_tests++;
        if (bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bad_clr got err=%b rdy=%b want 0 1", bus.err, bus.in_ready);
        end
    endtask

    task automatic test_zero_count;
        int base;
        base = wr_count;
        frame[0] = 8'hA5; frame[1] = 8'h00; frame[2] = 8'h00; frame[3] = 8'h00;
        frame_len = 4;
        send_frame(0);
        n_tests++;
        if (wr_count !== base || bus.done !== 1'b1 || bus.load_ok !== 1'b1 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL zero_count got nwr=%0d done=%b ok=%b err=%b want 0 1 1 0",
                wr_count - base, bus.done, bus.load_ok, bus.err);
        end
    endtask

    task automatic test_over_count;
        int base, dbase;
        @(posedge clk); #1;
        base = wr_count; dbase = done_count;
        frame[0] = 8'hA5; frame[1] = 8'h00; frame[2] = 8'h11;
        frame_len = 3;
        send_frame(0);
        n_tests++;
        if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.in_ready !== 1'b0 || bus.load_ok !== 1'b0) begin
            n_fail++; $display("FAIL over_status got err=%b done=%b rdy=%b ok=%b want 1 0 0 0",
                bus.err, bus.done, bus.in_ready, bus.load_ok);
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (wr_count !== base || done_count !== dbase || bus.cpu_hold !== 1'b0 || bus.err !== 1'b1) begin
            n_fail++; $display("FAIL over_quiet got nwr=%0d ndone=%0d hold=%b err=%b want 0 0 0 1",
                wr_count - base, done_count - dbase, bus.cpu_hold, bus.err);
        end
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        n_tests++;
        if (bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL over_clr got err=%b rdy=%b want 0 1", bus.err, bus.in_ready);
        end
    endtask

    task automatic test_noise_stall;
        int base, hbase;
        base = wr_count;
        frame[0] = 8'h00; frame[1] = 8'hFF; frame[2] = 8'h3C;
        frame_len = 3;
        send_frame(0);
        n_tests++;
        if (bus.cpu_hold !== 1'b0 || bus.in_ready !== 1'b1 || bus.done !== 1'b0 || wr_count !== base) begin
            n_fail++; $display("FAIL noise_ignored got hold=%b rdy=%b done=%b nwr=%0d want 0 1 0 0",
                bus.cpu_hold, bus.in_ready, bus.done, wr_count - base);
        end
        hbase = hold_count;
        load_good(8'h2E);
        send_frame(3);
        check_two_writes("stall", base, 16);
        n_tests++;
        if (bus.done !== 1'b1 || bus.load_ok !== 1'b1 || hold_count - hbase !== 44) begin
            n_fail++; $display("FAIL stall_status got done=%b ok=%b hold_cycles=%0d want 1 1 44",
                bus.done, bus.load_ok, hold_count - hbase);
        end
    endtask

    task automatic test_reset_mid_frame;
        int base;
        @(posedge clk); #1;
        base = wr_count;
        load_good(8'h2E);
        frame_len = 9;
        send_frame(0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if ({bus.in_ready, bus.wr_en, bus.cpu_hold, bus.done, bus.load_ok, bus.err} !== 6'b0 ||
            bus.wr_addr !== 32'h0 || bus.wr_data !== 32'h0) begin
            n_fail++; $display("FAIL midrst_outputs got rdy=%b we=%b hold=%b done=%b ok=%b err=%b a=%h d=%h want all 0",
                bus.in_ready, bus.wr_en, bus.cpu_hold, bus.done, bus.load_ok, bus.err, bus.wr_addr, bus.wr_data);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || wr_count - base !== 1 ||
            mon_addr[base] !== 32'h0 || mon_data[base] !== 32'h8C22000A) begin
            n_fail++; $display("FAIL midrst_partial got rdy=%b nwr=%0d w0=%h@%h want 1 1 8c22000a@00000000",
                bus.in_ready, wr_count - base, mon_data[base], mon_addr[base]);
        end
        base = wr_count;
        load_good(8'h2E);
        send_frame(0);
        check_two_writes("reload", base, 4);
        n_tests++;
        if (bus.done !== 1'b1 || bus.load_ok !== 1'b1 || bus.err !== 1'b0) begin
            n_fail++; $display("FAIL reload_status got done=%b ok=%b err=%b want 1 1 0", bus.done, bus.load_ok, bus.err);
        end
    endtask

    initial begin
        test_reset;
        test_good_frame;
        test_bad_checksum;
        test_zero_count;
        test_over_count;
        test_noise_stall;
        test_reset_mid_frame;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream programmer for the instruction memory: it is the write side of the byte-addressed, big-endian instruction store that the fetch stage reads. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and issues one word write per assembled word. It holds the pipeline in stall while loading and reports success or failure after checking an XOR checksum.

## Interface
- DEPTH_WORDS, 16: instruction memory capacity in 32-bit words; frames with a larger count are rejected.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.
- SYNC_BYTE, 8'hA5: frame start marker.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-low.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- clr  input  1  clears a sticky error and returns to IDLE.
- wr_en  output  1  one-cycle instruction memory write strobe.
- wr_addr  output  32  byte address, BASE_ADDR + 4*word_index.
- wr_data  output  32  word; first received byte in bits [31:24].
- cpu_hold  output  1  stall request to the pipeline while loading.
- done  output  1  one-cycle pulse when a frame completes, good or bad.
- load_ok  output  1  level: last frame loaded with a matching checksum.
- err  output  1  sticky level: frame rejected.

## Operation
- A byte is accepted on a rising edge when in_valid && in_ready.
- Frame format: SYNC_BYTE, count[15:8], count[7:0], 4*count payload bytes, checksum byte. The checksum is the XOR of all payload bytes only.
- IDLE: in_ready=1. Non-sync bytes are consumed and ignored. On a sync byte: go to CNT_HI, set cpu_hold=1, clear load_ok, and clear the checksum accumulator, word index and byte counter.
- CNT_HI: latch count[15:8] and go to CNT_LO.
- CNT_LO: latch count[7:0], then:
  - count > DEPTH_WORDS -> ERR;
  - count == 0 -> CSUM;
  - otherwise -> DATA.
- DATA:
  - Shift each byte into a 32-bit assembly register (MSB first) and XOR it into the accumulator.
  - On the 4th byte of a word, register wr_data and wr_addr, pulse wr_en, increment the word index, and reset the byte counter.
  - After the word with index count-1 is accepted, go to CSUM.
- CSUM:
  - Byte == accumulator -> load_ok=1.
  - Otherwise -> err=1.
  - Either way: pulse done, drop cpu_hold, and go to IDLE on match or ERR on mismatch.
- ERR: in_ready=0, cpu_hold=0, err=1. Leaves only via clr=1 (-> IDLE, err cleared) or reset.
- clr in any non-ERR state is ignored.
- A sync byte received in DATA or CSUM is treated as data; there is no resync mid-frame.
- Word index is 16 bits wide. wr_addr = BASE_ADDR + {index, 2'b00}, 32-bit arithmetic, with no wrap because count ≤ DEPTH_WORDS.

## Timing
- Reset (rst=0 at a clock edge): state IDLE; in_ready=0 during reset and 1 from the first cycle after release. wr_en, wr_addr, wr_data, cpu_hold, done, load_ok and err are all 0; the accumulator and counters are 0.
- Reset mid-frame aborts with no further writes. Words already written stay in memory.
- cpu_hold rises the cycle after the sync byte is accepted. It falls the cycle after the checksum byte is accepted, or the cycle after entering ERR.
- wr_en is high exactly the cycle after the 4th byte of a word is accepted. wr_addr and wr_data hold their values until the next write.
- in_ready stays 1 through DATA: one byte per cycle is sustained with no bubbles. Back-to-back words give wr_en every 4th cycle.
- done is high the cycle after the checksum byte is accepted; load_ok and err update in that same cycle.
- The over-count rejection asserts err (without done) the cycle after count[7:0] is accepted.
- in_valid gaps are allowed anywhere; the state holds with no timeout.

## Test plan
- **Good 2-word frame.** Send A5 00 02 8C 22 00 0A AC 23 00 05 2E back-to-back.
  - Write 0x8C22000A at address 0x0, then 0xAC230005 at 0x4, with wr_en 4 cycles apart.
  - done pulse, load_ok=1, err=0; cpu_hold high from the cycle after A5 to the cycle after 2E.
- **Bad checksum.** Same frame with 2F as the last byte.
  - Both writes still occur; done=1, err=1, load_ok=0, in_ready=0.
  - After clr=1 for one cycle: err=0, in_ready=1.
- **Zero and over-count.**
  - A5 00 00 00 -> no wr_en, done, load_ok=1.
  - A5 00 11 (17 > 16) -> err=1 the next cycle, no done, no writes.
- **Idle noise and stalls.**
  - Send 00 FF 3C before a good frame; they are consumed and ignored.
  - Toggle in_valid low for 3 cycles between each byte: identical writes and addresses to the back-to-back case.
- **Reset mid-frame.** Assert rst=0 after the 6th payload byte.
  - One write at 0x0 only; all outputs 0; in_ready=1 one cycle after release.
  - A new good frame then loads correctly.
